// File: rtl/inv_mixcolumn_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_mixcolumn_seq
// Purpose  : Iterative AES InvMixColumns engine for the AES-128 decrypt
//            round loop. Accepts a 128-bit state over valid/ready, rewrites
//            COLS_PER_CYCLE columns per clock in place, and holds the result
//            until the downstream stage takes it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   COLS_PER_CYCLE : columns transformed per clock (1, 2 or 4);
//                    latency = 4/COLS_PER_CYCLE cycles.
// Optional feature macro:
//   MIXCOL_FWD_MODE_EN : adds input fwd_mode; when 1 at acceptance the state
//                        gets forward MixColumns instead of the inverse.
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    in_state is valid
//   in_ready   out  1    block accepts in_state this cycle
//   in_state   in   128  column c = in_state[127-32c -: 32], top byte [31:24]
//   fwd_mode   in   1    (MIXCOL_FWD_MODE_EN only) forward-transform select
//   out_valid  out  1    out_state holds a completed result
//   out_ready  in   1    downstream accepts out_state
//   out_state  out  128  transformed state, same layout as in_state
//   busy       out  1    columns are being processed
// ============================================================================
module inv_mixcolumn_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef MIXCOL_FWD_MODE_EN
  input  logic         fwd_mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter guard
  // --------------------------------------------------------------------------
  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("inv_mixcolumn_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Column counter step and the counter value of the final group. With four
  // columns per cycle the step truncates to 0 and the first group is the last.
  localparam logic [1:0] c_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] c_LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // --------------------------------------------------------------------------
  // GF(2^8) helpers, reduction polynomial x^8+x^4+x^3+x+1
  // --------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through either InvMixColumns (fwd=0) or MixColumns (fwd=1).
  // All constant multiples are built from the x2/x4/x8 chain of each byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic fwd);
    logic [7:0] b  [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x4;
    logic [7:0] x8;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      b[i]  = col[31-8*i -: 8];
      m2[i] = xtime(b[i]);
      x4    = xtime(m2[i]);
      x8    = xtime(x4);
      m3[i] = m2[i] ^ b[i];
      m9[i] = x8 ^ b[i];
      mb[i] = x8 ^ m2[i] ^ b[i];
      md[i] = x8 ^ x4 ^ b[i];
      me[i] = x8 ^ x4 ^ m2[i];
    end
    res = '0;
    for (int i = 0; i < 4; i++) begin
      if (fwd) begin
        res[31-8*i -: 8] = m2[i] ^ m3[(i+1)%4] ^ b[(i+2)%4] ^ b[(i+3)%4];
      end else begin
        res[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
      end
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  fsm_t         fsm_q,   fsm_d;
  logic [127:0] state_q, state_d;
  logic [1:0]   cnt_q,   cnt_d;
  logic         fwd_q;
  logic         accept;

  // --------------------------------------------------------------------------
  // Column units: unit g works on column cnt_q+g of the held state
  // --------------------------------------------------------------------------
  logic [1:0]  unit_idx [COLS_PER_CYCLE];
  logic [31:0] unit_out [COLS_PER_CYCLE];

  generate
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
      logic [31:0] col_in;
      assign unit_idx[g] = cnt_q + 2'(g);
      // {~idx, 5'h1F} is 127-32*idx, the MSB of column idx.
      assign col_in      = state_q[{~unit_idx[g], 5'h1F} -: 32];
      assign unit_out[g] = mix_col(col_in, fwd_q);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      BUSY: begin
        busy = 1'b1;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          state_d[{~unit_idx[g], 5'h1F} -: 32] = unit_out[g];
        end
        cnt_d = cnt_q + c_STEP;
        if (cnt_q == c_LAST) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // A new state may only enter when the current result leaves.
        in_ready  = out_ready;
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

    accept = in_valid && in_ready;
    if (accept) begin
      state_d = in_state;
      cnt_d   = 2'd0;
      fsm_d   = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MIXCOL_FWD_MODE_EN
  // Mode is captured with the state and held for the whole operation.
  logic fwd_d;
  always_comb begin
    fwd_d = fwd_q;
    if (accept) begin
      fwd_d = fwd_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q <= 1'b0;
    end else begin
      fwd_q <= fwd_d;
    end
  end
`else
  assign fwd_q = 1'b0;
`endif

  // The state register doubles as the result register: it is only rewritten
  // in BUSY or on acceptance, so it is stable throughout DONE.
  assign out_state = state_q;

  // --------------------------------------------------------------------------
  // Protocol properties
  // --------------------------------------------------------------------------
  a_hold_result : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_state)));

  a_busy_excl : assert property (@(posedge clk) disable iff (rst)
    !(busy && (out_valid || in_ready)));

endmodule
`default_nettype wire

// File: tb/tb_inv_mixcolumn_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_mixcolumn_seq
// Purpose  : Self-checking bench for inv_mixcolumn_seq. Three instances
//            (1, 2 and 4 columns per cycle) share stimulus; instance 1 also
//            runs the backpressure, back-to-back and reset sequences.
//            With MIXCOL_FWD_MODE_EN defined, forward mode and round trips
//            are exercised as well.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_mixcolumn_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;
`ifdef MIXCOL_FWD_MODE_EN
  logic         fwd_mode;
`endif

  logic         in_ready1, out_valid1, busy1;
  logic [127:0] out_state1;
  logic         in_ready2, out_valid2, busy2;
  logic [127:0] out_state2;
  logic         in_ready4, out_valid4, busy4;
  logic [127:0] out_state4;

  inv_mixcolumn_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_state(in_state),
`ifdef MIXCOL_FWD_MODE_EN
    .fwd_mode(fwd_mode),
`endif
    .out_valid(out_valid1), .out_ready(out_ready), .out_state(out_state1),
    .busy(busy1)
  );

  inv_mixcolumn_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_state(in_state),
`ifdef MIXCOL_FWD_MODE_EN
    .fwd_mode(fwd_mode),
`endif
    .out_valid(out_valid2), .out_ready(out_ready), .out_state(out_state2),
    .busy(busy2)
  );

  inv_mixcolumn_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_state(in_state),
`ifdef MIXCOL_FWD_MODE_EN
    .fwd_mode(fwd_mode),
`endif
    .out_valid(out_valid4), .out_ready(out_ready), .out_state(out_state4),
    .busy(busy4)
  );

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  // Single transaction on instance 1: returns result and edges to out_valid.
  task automatic run_op(input logic [127:0] din, output logic [127:0] res, output int lat);
    int w;
    lat = -1;
    res = '0;
    @(negedge clk);
    in_state  = din;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    w = 0;
    while (!in_ready1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_state = ~din;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid1) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) timeout_fail("run_op out_valid");
    res = out_state1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res;
    logic [127:0] rnd;
    logic [127:0] fwd_res;
    int lat, lat1, lat2, lat4, nbusy, gap, w;
    logic idle_seen;

    vecs[0] = '{din: 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
                exp: 128'hdb135345_f20a225c_01010101_d4d4d4d5};
    vecs[1] = '{din: 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6,
                exp: 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6};
    vecs[2] = '{din: 128'h4d7ebdf8_00000000_01010101_c6c6c6c6,
                exp: 128'h2d26314c_00000000_01010101_c6c6c6c6};
    vecs[3] = '{din: 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d,
                exp: 128'hd4d4d4d5_2d26314c_db135345_f20a225c};
    vecs[4] = '{din: 128'h01000000_00010000_00000001_80000000,
                exp: 128'h0e090d0b_0b0e090d_090d0b0e_41ecdaf7};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
`ifdef MIXCOL_FWD_MODE_EN
    fwd_mode  = 1'b0;
`endif

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready",  in_ready1,  1);
    check("reset out_valid", out_valid1, 0);
    check("reset busy",      busy1,      0);
    check("reset out_state", out_state1, 0);
    rst = 1'b0;

    // ---------------- table: all three widths ----------------
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_state = vecs[i].din;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_state = ~vecs[i].din;
      lat1 = -1; lat2 = -1; lat4 = -1; nbusy = 0;
      for (int c = 0; c <= 8; c++) begin
        if (c > 0) @(negedge clk);
        if (busy1) nbusy++;
        if (lat1 < 0 && out_valid1) lat1 = c;
        if (lat2 < 0 && out_valid2) lat2 = c;
        if (lat4 < 0 && out_valid4) lat4 = c;
      end
      check($sformatf("vec%0d out_state c1", i), out_state1, vecs[i].exp);
      check($sformatf("vec%0d out_state c2", i), out_state2, vecs[i].exp);
      check($sformatf("vec%0d out_state c4", i), out_state4, vecs[i].exp);
      check($sformatf("vec%0d latency c1", i), 128'(lat1), 128'(4));
      check($sformatf("vec%0d latency c2", i), 128'(lat2), 128'(2));
      check($sformatf("vec%0d latency c4", i), 128'(lat4), 128'(1));
      check($sformatf("vec%0d busy cycles c1", i), 128'(nbusy), 128'(4));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check($sformatf("vec%0d idle after take", i),
            {out_valid1, out_valid2, out_valid4, in_ready1}, 4'b0001);
    end

    // ---------------- backpressure ----------------
    @(negedge clk);
    in_state = vecs[0].din;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid1) timeout_fail("backpressure out_valid");
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp hold state k%0d", k), out_state1, vecs[0].exp);
      check($sformatf("bp flags k%0d", k), {out_valid1, in_ready1, busy1}, 3'b100);
      in_valid = k[0];
      in_state = {4{$urandom}};
      @(negedge clk);
    end
    in_valid  = 1'b0;
    check("bp still held", {out_valid1, out_state1}, {1'b1, vecs[0].exp});
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release idle", {out_valid1, in_ready1, busy1}, 3'b010);
    out_ready = 1'b0;

    // ---------------- back-to-back ----------------
    @(negedge clk);
    in_state  = vecs[0].din;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_state  = vecs[1].din;
    w = 0;
    while (!out_valid1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid1) timeout_fail("b2b first out_valid");
    check("b2b first result", out_state1, vecs[0].exp);
    check("b2b in_ready in DONE", in_ready1, 1);
    gap = -1;
    idle_seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (!busy1 && !out_valid1) idle_seen = 1'b1;
      if (out_valid1) begin
        gap = c;
        break;
      end
    end
    check("b2b result spacing", 128'(gap), 128'(5));
    check("b2b no idle cycle", idle_seen, 0);
    check("b2b second result", out_state1, vecs[1].exp);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b idle after", {out_valid1, in_ready1}, 2'b01);

    // ---------------- reset mid-operation ----------------
    @(negedge clk);
    in_state = vecs[4].din;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst first busy cycle", busy1, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst abort flags", {out_valid1, in_ready1, busy1}, 3'b010);
    check("rst abort out_state", out_state1, 0);
    run_op(vecs[3].din, res, lat);
    check("after rst result", res, vecs[3].exp);
    check("after rst latency", 128'(lat), 128'(4));

`ifdef MIXCOL_FWD_MODE_EN
    // ---------------- forward mode ----------------
    fwd_mode = 1'b1;
    run_op(vecs[0].exp, res, lat);
    check("fwd known vector", res, vecs[0].din);
    check("fwd latency", 128'(lat), 128'(4));
    for (int r = 0; r < 4; r++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      fwd_mode = 1'b1;
      run_op(rnd, fwd_res, lat);
      fwd_mode = 1'b0;
      run_op(fwd_res, res, lat);
      check($sformatf("round trip %0d", r), res, rnd);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
